// File: rtl/calc_pkg.sv
// calc_pkg: op codes and FSM state encoding shared by the sequential calculator
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// seq_divider: W-iteration restoring divider with zero-divisor detection
module seq_divider
    import calc_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start_i,
    input  logic [W-1:0] dvd_i,
    input  logic [W-1:0] dvs_i,
    output logic         last_o,
    output logic         err_o,
    output logic [W-1:0] quo_o,
    output logic [W-1:0] rem_o
);

    localparam int CW = $clog2(W);

    logic          run_q, run_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [W:0]    shift;
    logic [W:0]    trial;
    logic          fits;
    logic [W-1:0]  quo_nx;
    logic [W-1:0]  rem_nx;

    // One restoring step per cycle; a zero divisor finishes on the first cycle
    always_comb begin
        shift  = {rem_q, quo_q[W-1]};
        trial  = shift - {1'b0, dvs_q};
        fits   = ~trial[W];
        quo_nx = {quo_q[W-2:0], fits};
        rem_nx = fits ? trial[W-1:0] : shift[W-1:0];
        err_o  = (dvs_q == '0);
        last_o = run_q && (err_o || cnt_q == CW'(W - 1));
        quo_o  = err_o ? '1 : quo_nx;
        rem_o  = err_o ? quo_q : rem_nx;
        run_d  = start_i ? 1'b1 : (run_q && !last_o);
        cnt_d  = start_i ? '0 : (run_q ? cnt_q + 1'b1 : cnt_q);
        quo_d  = start_i ? dvd_i : (run_q ? quo_nx : quo_q);
        rem_d  = start_i ? '0 : (run_q ? rem_nx : rem_q);
        dvs_d  = start_i ? dvs_i : dvs_q;
    end

    // Iteration state registers
    always_ff @(posedge clk) begin
        if (clr) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

endmodule

// File: rtl/seq_calculator.sv
// seq_calculator: multi-cycle add/sub/mul/div core with start/busy/done handshake; CALC_ANS_EN adds use_ans chaining
module seq_calculator
    import calc_pkg::*;
#(
    parameter int W  = 4,
    parameter int RW = 2 * W
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
`ifdef CALC_ANS_EN
    input  logic          use_ans,
`endif
    output logic          busy,
    output logic          done,
    output logic [RW-1:0] result,
    output logic [W-1:0]  remainder,
    output logic          neg,
    output logic          err
);

    localparam int CW = $clog2(W);

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] opa_q, opa_d;
    logic [W-1:0]  opb_q, opb_d;
    logic [RW-1:0] prod_q, prod_d;
    logic [RW-1:0] result_q, result_d;
    logic [W-1:0]  rem_q, rem_d;
    logic          neg_q, neg_d;
    logic          err_q, err_d;
    logic [W-1:0]  a_eff;
    logic          accept;
    logic          fin;
    logic [RW-1:0] mul_acc;
    logic          div_last;
    logic          div_err;
    logic [W-1:0]  div_quo;
    logic [W-1:0]  div_rem;

`ifdef CALC_ANS_EN
    assign a_eff = use_ans ? result_q[W-1:0] : a;
`else
    assign a_eff = a;
`endif

    assign accept    = start && state_q != CALC;
    assign busy      = state_q == CALC;
    assign done      = state_q == DONE;
    assign result    = result_q;
    assign remainder = rem_q;
    assign neg       = neg_q;
    assign err       = err_q;

    seq_divider #(.W(W)) u_div (
        .clk     (clk),
        .clr     (clr),
        .start_i (accept && op == OP_DIV),
        .dvd_i   (a_eff),
        .dvs_i   (b),
        .last_o  (div_last),
        .err_o   (div_err),
        .quo_o   (div_quo),
        .rem_o   (div_rem)
    );

    // Next state, shift-add multiplier step and result capture on the finishing edge
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        prod_d   = prod_q;
        result_d = result_q;
        rem_d    = rem_q;
        neg_d    = neg_q;
        err_d    = err_q;
        mul_acc  = prod_q + (opb_q[0] ? opa_q : '0);
        fin      = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                   (op_q == OP_MUL && cnt_q == CW'(W - 1)) ||
                   (op_q == OP_DIV && div_last);
        if (state_q == CALC) begin
            cnt_d  = cnt_q + 1'b1;
            opa_d  = opa_q << 1;
            opb_d  = opb_q >> 1;
            prod_d = mul_acc;
            if (fin) begin
                state_d  = DONE;
                result_d = op_q == OP_ADD ? opa_q + {{W{1'b0}}, opb_q} :
                           op_q == OP_SUB ? opa_q - {{W{1'b0}}, opb_q} :
                           op_q == OP_MUL ? mul_acc : {{W{1'b0}}, div_quo};
                rem_d    = op_q == OP_DIV ? div_rem : '0;
                neg_d    = op_q == OP_SUB && opa_q[W-1:0] < opb_q;
                err_d    = op_q == OP_DIV && div_err;
            end
        end else if (start) begin
            state_d = CALC;
            op_d    = op;
            cnt_d   = '0;
            opa_d   = {{W{1'b0}}, a_eff};
            opb_d   = b;
            prod_d  = '0;
        end else begin
            state_d = IDLE;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            prod_q   <= '0;
            result_q <= '0;
            rem_q    <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_seq_calculator.sv
// tb_seq_calculator: directed self-checking bench for seq_calculator at W=4
module tb_seq_calculator;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       use_ans = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [3:0] remainder;
    logic       neg;
    logic       err;
    int         total = 0;
    int         bad = 0;
    int         cyc;
    int         seen;

    seq_calculator #(.W(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
`ifdef CALC_ANS_EN
        .use_ans   (use_ans),
`endif
        .busy      (busy),
        .done      (done),
        .result    (result),
        .remainder (remainder),
        .neg       (neg),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one request, let edge n accept it, then scramble the inputs
    task automatic issue(input logic [1:0] o, input logic [3:0] x, input logic [3:0] y);
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = ~o;
        a = ~x;
        b = ~y;
    endtask

    // Wait (bounded) for done, counting edges since edge n
    task automatic finish(input string tag, input int base, input int lat);
        cyc = base;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_lat"}, cyc, lat);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res", result, 0);
        check("rst_rem", remainder, 0);
        check("rst_flags", {neg, err}, 0);

        issue(2'b00, 4'd9, 4'd7);
        check("add_busy_n", busy, 1);
        finish("add", 0, 1);
        check("add_res", result, 8'h10);
        check("add_neg", neg, 0);

        issue(2'b01, 4'd3, 4'd5);
        finish("sub", 0, 1);
        check("sub_res", result, 8'hFE);
        check("sub_neg", neg, 1);

        issue(2'b01, 4'd5, 4'd5);
        finish("sub0", 0, 1);
        check("sub0_res", result, 8'h00);
        check("sub0_neg", neg, 0);

        issue(2'b11, 4'd15, 4'd15);
        check("mul_hold", result, 8'h00);
        finish("mul", 0, 4);
        check("mul_res", result, 8'hE1);
        @(posedge clk);
        #1;
        check("mul_idle_hold", result, 8'hE1);
        check("mul_idle_done", done, 0);

        issue(2'b11, 4'd6, 4'd7);
        @(posedge clk);
        #1;
        start = 1'b1;
        op = 2'b00;
        a = 4'd1;
        b = 4'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish("repulse", 2, 4);
        check("repulse_res", result, 8'd42);

        issue(2'b10, 4'd13, 4'd4);
        finish("div", 0, 4);
        check("div_res", result, 8'd3);
        check("div_rem", remainder, 4'd1);
        check("div_err", err, 0);

        issue(2'b10, 4'd13, 4'd0);
        finish("div0", 0, 1);
        check("div0_res", result, 8'h0F);
        check("div0_rem", remainder, 4'd13);
        check("div0_err", err, 1);

        issue(2'b00, 4'd15, 4'd15);
        finish("add2", 0, 1);
        check("add2_res", result, 8'h1E);
        check("add2_flags", {remainder, neg, err}, 0);

        issue(2'b11, 4'd15, 4'd15);
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr_busy", busy, 0);
        check("clr_done", done, 0);
        check("clr_res", result, 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("clr_nodone", seen, 0);

        @(negedge clk);
        start = 1'b1;
        op = 2'b00;
        a = 4'd9;
        b = 4'd7;
        @(posedge clk);
        #1;
        a = 4'd2;
        b = 4'd3;
        @(posedge clk);
        #1;
        check("b2b_done1", done, 1);
        check("b2b_res1", result, 8'h10);
        @(posedge clk);
        #1;
        check("b2b_busy2", busy, 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_done2", done, 1);
        check("b2b_res2", result, 8'd5);

`ifdef CALC_ANS_EN
        issue(2'b00, 4'd9, 4'd7);
        finish("ans_add", 0, 1);
        use_ans = 1'b1;
        issue(2'b11, 4'd5, 4'd2);
        use_ans = 1'b0;
        finish("ans_mul", 0, 4);
        check("ans_mul_res", result, 8'h00);
        issue(2'b00, 4'd3, 4'd4);
        finish("ans_add2", 0, 1);
        use_ans = 1'b1;
        issue(2'b01, 4'd9, 4'd2);
        use_ans = 1'b0;
        finish("ans_sub", 0, 1);
        check("ans_sub_res", result, 8'd5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_calculator.md
Name: seq_calculator

Overview:
- Parametrised, multi-cycle successor to the board calculator's arithmetic core.
- Takes two W-bit unsigned operands and a 2-bit op code.
  - Add and subtract complete in a single cycle.
  - Multiply uses shift-add over W iterations.
  - Divide uses restoring division over W iterations.
- Uses a start/busy/done handshake.
- Sits between the switch/button front end and the BCD/seven-segment display path. result feeds binary_to_BCD.

Parameters:
- W, 4, operand width in bits (valid range 2..16).
- RW, 2*W, result width (derived; do not override).

Ports:
- clk  in  1  system clock; all logic on rising edge
- clr  in  1  synchronous active-high reset
- start  in  1  request; sampled only while idle
- op  in  2  operation code: 00 add, 01 sub, 10 div, 11 mul (equals {btn[1],btn[0]})
- a  in  W  operand A (dividend / minuend)
- b  in  W  operand B (divisor / subtrahend)
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse: result valid
- result  out  RW  add/sub/mul result, or zero-extended quotient for div
- remainder  out  W  remainder for div; 0 for all other ops
- neg  out  1  sub only: a < b
- err  out  1  div only: divisor zero

Behaviour:
- Reset:
  - clr sampled high at an edge forces IDLE.
  - busy=0, done=0, result=0, remainder=0, neg=0, err=0.
  - Internal counter and shift registers cleared.
  - clr overrides start. Reset mid-operation aborts with no done pulse.
- FSM states:
  - IDLE: start=1 at edge n latches a, b, op and goes to CALC. busy=1 from after edge n.
  - CALC:
    - add/sub/div-by-zero: one cycle.
    - mul/div: W iterations, counter counts 0..W-1.
    - At the last iteration edge, registers result and flags, goes to DONE.
  - DONE: done=1, busy=0 for exactly one cycle, then IDLE.
    - start=1 in DONE is accepted as if in IDLE, giving back-to-back operation.
- Latency:
  - add/sub: done high in the cycle after edge n+1.
  - mul/div: done high in the cycle after edge n+W.
- Handshake:
  - start while busy is ignored, with no queueing.
  - a, b and op may change freely after edge n.
- Arithmetic:
  - add: result = a+b zero-extended; carry appears at bit W.
  - sub: result = (a-b) mod 2^RW, i.e. sign-extended two's complement; neg = (a<b).
  - mul: result = full unsigned product a*b; maximum (2^W-1)^2 fits in RW.
  - div:
    - result = floor(a/b) zero-extended; remainder = a mod b.
    - b=0 takes one cycle: err=1, result = all ones (W low bits set, upper zeros), remainder = a.
- Flag validity:
  - neg, err and remainder are updated together with result.
  - Flags not applicable to the current op are 0.
- Hold: result, remainder and flags hold their value until the next accepted start completes. They do not clear on start.

Optional Feature:
- Macro: CALC_ANS_EN.
- Defined:
  - Adds input port use_ans (1 bit).
  - If use_ans=1 when start is accepted, operand A = result[W-1:0] of the previous operation; port a is ignored. This enables chained calculations.
  - After reset, the ANS value is 0.
- Undefined: no use_ans port; operand A is always port a.

Decomposition:
- Package calc_pkg:
  - op code constants OP_ADD=2'b00, OP_SUB=2'b01, OP_DIV=2'b10, OP_MUL=2'b11.
  - FSM state encoding IDLE/CALC/DONE.
- Sub-module seq_divider:
  - W-iteration restoring divider with its own start and last-iteration strobe.
  - Handles the zero-divisor check.
  - Instantiated by seq_calculator.
- Multiplier shift-add datapath stays inline.

Test Plan (W=4):
- add a=9, b=7: done after edge n+1 → result=8'h10, neg=0, busy low at done.
- sub a=3, b=5: result=8'hFE, neg=1.
- sub a=5, b=5: result=0, neg=0.
- mul a=15, b=15: busy for 4 edges, done after edge n+4 → result=8'hE1.
- mul with start re-pulsed at n+2: re-pulse ignored, result unchanged by it.
- div a=13, b=4: result=3, remainder=1, err=0 after 4 iterations.
- div a=13, b=0: one-cycle completion, err=1, result=8'h0F, remainder=13.
- clr asserted at n+2 of a mul: next cycle busy=0, done=0, result=0, and no done pulse follows.
- back-to-back: start held high through DONE of an add → second op accepted with no idle gap.
- CALC_ANS_EN: add 9+7, then use_ans=1 with mul b=2 → result=0 (0x10 low nibble = 0 times 2).
